// File: rtl/pipelined_int_core.sv
// Five-stage MIPS-I integer pipeline (IF/ID/EX/MEM/WB) with ID-stage branch/JR
// resolution, forwarding and trap flags. Optional counters: PIPE_PERF_COUNTERS_EN.
module pipelined_int_core #(
    parameter int                  DATA_WIDTH     = 32,
    parameter int                  PC_WIDTH       = 32,
    parameter int                  REG_ADDR_WIDTH = 5,
    parameter logic [PC_WIDTH-1:0] RESET_PC       = {PC_WIDTH{1'b0}}
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic [PC_WIDTH-1:0]       PC,
    input  logic                      fetch_valid,
    input  logic [31:0]               current_instruction,
    output logic [REG_ADDR_WIDTH-1:0] register_file_read_address_1,
    output logic [REG_ADDR_WIDTH-1:0] register_file_read_address_2,
    input  logic [DATA_WIDTH-1:0]     register_file_read_value_1,
    input  logic [DATA_WIDTH-1:0]     register_file_read_value_2,
    output logic [REG_ADDR_WIDTH-1:0] register_file_write_address,
    output logic [DATA_WIDTH-1:0]     register_file_write_value,
    output logic                      register_file_write_enable,
    output logic                      illegal_instr,
    output logic                      overflow
`ifdef PIPE_PERF_COUNTERS_EN
    ,
    output logic [31:0]               cycle_count,
    output logic [31:0]               retire_count,
    output logic [31:0]               fetch_stall_count
`endif
);

    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO  = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0]     DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam int                        MSB       = DATA_WIDTH - 1;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
    } alu_op_e;
    typedef enum logic [1:0] {IMM_NONE, IMM_SEXT, IMM_ZEXT, IMM_LUI} imm_kind_e;

    logic [PC_WIDTH-1:0]       pc_q, pc_d, ifid_pc_q, ifid_pc_d;
    logic                      ifid_valid_q, ifid_valid_d;
    logic [31:0]               ifid_instr_q, ifid_instr_d;
    logic                      idex_valid_q, idex_valid_d, idex_wr_q, idex_wr_d, idex_trap_q, idex_trap_d;
    alu_op_e                   idex_op_q, idex_op_d;
    logic [DATA_WIDTH-1:0]     idex_a_q, idex_a_d, idex_b_q, idex_b_d;
    logic [4:0]                idex_shamt_q, idex_shamt_d;
    logic [REG_ADDR_WIDTH-1:0] idex_dest_q, idex_dest_d;
    logic                      exmem_valid_q, exmem_valid_d, exmem_wr_q, exmem_wr_d;
    logic [REG_ADDR_WIDTH-1:0] exmem_dest_q, exmem_dest_d;
    logic [DATA_WIDTH-1:0]     exmem_res_q, exmem_res_d;
    logic                      memwb_valid_q, memwb_valid_d, memwb_wr_q, memwb_wr_d;
    logic [REG_ADDR_WIDTH-1:0] memwb_dest_q, memwb_dest_d;
    logic [DATA_WIDTH-1:0]     memwb_res_q, memwb_res_d;
    logic                      illegal_q, illegal_d, overflow_q, overflow_d;

    logic [5:0]                opcode_s, funct_s;
    logic [4:0]                shamt_s;
    logic [15:0]               imm_s;
    logic [REG_ADDR_WIDTH-1:0] rs_addr_s, rt_addr_s, dest_s;
    logic                      dec_legal_s, dec_writes_s, dec_trap_s, dec_use_rd_s;
    logic                      dec_jr_s, dec_beq_s, dec_bne_s, shamt_ok_s, redirect_s;
    alu_op_e                   dec_op_s;
    imm_kind_e                 dec_imm_s;
    logic [DATA_WIDTH-1:0]     fwd_a_s, fwd_b_s, op_b_s, ex_result_s, add_s, sub_s;
    logic [PC_WIDTH-1:0]       target_s;
    logic                      ex_ovf_s, ex_wr_s;

    assign opcode_s   = ifid_instr_q[31:26];
    assign funct_s    = ifid_instr_q[5:0];
    assign shamt_s    = ifid_instr_q[10:6];
    assign imm_s      = ifid_instr_q[15:0];
    assign rs_addr_s  = REG_ADDR_WIDTH'(ifid_instr_q[25:21]);
    assign rt_addr_s  = ((opcode_s == 6'h00) || (opcode_s == 6'h04) || (opcode_s == 6'h05))
                        ? REG_ADDR_WIDTH'(ifid_instr_q[20:16]) : REG_ZERO;
    assign dest_s     = dec_use_rd_s ? REG_ADDR_WIDTH'(ifid_instr_q[15:11])
                                     : REG_ADDR_WIDTH'(ifid_instr_q[20:16]);
    assign shamt_ok_s = (shamt_s == 5'd0) || (funct_s == 6'h00) || (funct_s == 6'h02) || (funct_s == 6'h03);

    // Instruction decode into ALU op, immediate kind and control flags.
    always_comb begin
        dec_legal_s  = 1'b1;
        dec_writes_s = 1'b1;
        dec_trap_s   = 1'b0;
        dec_use_rd_s = 1'b0;
        dec_jr_s     = 1'b0;
        dec_beq_s    = 1'b0;
        dec_bne_s    = 1'b0;
        dec_op_s     = ALU_ADD;
        dec_imm_s    = IMM_SEXT;
        case (opcode_s)
            6'h00: begin
                dec_use_rd_s = 1'b1;
                dec_imm_s    = IMM_NONE;
                case (funct_s)
                    6'h20: dec_trap_s = 1'b1;
                    6'h21: dec_op_s = ALU_ADD;
                    6'h22: begin dec_op_s = ALU_SUB; dec_trap_s = 1'b1; end
                    6'h23: dec_op_s = ALU_SUB;
                    6'h24: dec_op_s = ALU_AND;
                    6'h25: dec_op_s = ALU_OR;
                    6'h26: dec_op_s = ALU_XOR;
                    6'h27: dec_op_s = ALU_NOR;
                    6'h2A: dec_op_s = ALU_SLT;
                    6'h2B: dec_op_s = ALU_SLTU;
                    6'h00: dec_op_s = ALU_SLL;
                    6'h02: dec_op_s = ALU_SRL;
                    6'h03: dec_op_s = ALU_SRA;
                    6'h08: begin dec_jr_s = 1'b1; dec_writes_s = 1'b0; end
                    default: dec_legal_s = 1'b0;
                endcase
                dec_legal_s = dec_legal_s && shamt_ok_s;
            end
            6'h08: dec_trap_s = 1'b1;
            6'h09: dec_op_s = ALU_ADD;
            6'h0A: dec_op_s = ALU_SLT;
            6'h0B: dec_op_s = ALU_SLTU;
            6'h0C: begin dec_op_s = ALU_AND; dec_imm_s = IMM_ZEXT; end
            6'h0D: begin dec_op_s = ALU_OR;  dec_imm_s = IMM_ZEXT; end
            6'h0E: begin dec_op_s = ALU_XOR; dec_imm_s = IMM_ZEXT; end
            6'h0F: begin dec_op_s = ALU_PASSB; dec_imm_s = IMM_LUI; end
            6'h04: begin dec_beq_s = 1'b1; dec_writes_s = 1'b0; dec_imm_s = IMM_NONE; end
            6'h05: begin dec_bne_s = 1'b1; dec_writes_s = 1'b0; dec_imm_s = IMM_NONE; end
            default: dec_legal_s = 1'b0;
        endcase
    end

    // Youngest producer wins; $0 and non-writing or invalid stages never forward.
    function automatic logic [DATA_WIDTH-1:0] fwd_operand(
        input logic [REG_ADDR_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] rf_val,
        input logic ex_hit, input logic mem_hit, input logic wb_hit,
        input logic [DATA_WIDTH-1:0] ex_val, input logic [DATA_WIDTH-1:0] mem_val,
        input logic [DATA_WIDTH-1:0] wb_val);
        logic [DATA_WIDTH-1:0] v;
        if (addr == REG_ZERO)  v = DATA_ZERO;
        else if (ex_hit)       v = ex_val;
        else if (mem_hit)      v = mem_val;
        else if (wb_hit)       v = wb_val;
        else                   v = rf_val;
        return v;
    endfunction

    assign fwd_a_s = fwd_operand(rs_addr_s, register_file_read_value_1,
        ex_wr_s && (idex_dest_q == rs_addr_s),
        exmem_valid_q && exmem_wr_q && (exmem_dest_q == rs_addr_s),
        memwb_valid_q && memwb_wr_q && (memwb_dest_q == rs_addr_s),
        ex_result_s, exmem_res_q, memwb_res_q);
    assign fwd_b_s = fwd_operand(rt_addr_s, register_file_read_value_2,
        ex_wr_s && (idex_dest_q == rt_addr_s),
        exmem_valid_q && exmem_wr_q && (exmem_dest_q == rt_addr_s),
        memwb_valid_q && memwb_wr_q && (memwb_dest_q == rt_addr_s),
        ex_result_s, exmem_res_q, memwb_res_q);

    // Second ALU operand selection and control-flow target.
    always_comb begin
        case (dec_imm_s)
            IMM_SEXT: op_b_s = DATA_WIDTH'($signed(imm_s));
            IMM_ZEXT: op_b_s = DATA_WIDTH'(imm_s);
            IMM_LUI:  op_b_s = DATA_WIDTH'($signed({imm_s, 16'h0000}));
            default:  op_b_s = fwd_b_s;
        endcase
        redirect_s = ifid_valid_q && dec_legal_s &&
                     (dec_jr_s || (dec_beq_s && (fwd_a_s == fwd_b_s)) || (dec_bne_s && (fwd_a_s != fwd_b_s)));
        if (dec_jr_s) target_s = PC_WIDTH'(fwd_a_s);
        else          target_s = ifid_pc_q + PC_WIDTH'(32'd4) + PC_WIDTH'($signed({imm_s, 2'b00}));
    end

    assign add_s = idex_a_q + idex_b_q;
    assign sub_s = idex_a_q - idex_b_q;

    // Execute stage ALU and signed-overflow detection for trapping ops.
    always_comb begin
        case (idex_op_q)
            ALU_ADD:   ex_result_s = add_s;
            ALU_SUB:   ex_result_s = sub_s;
            ALU_AND:   ex_result_s = idex_a_q & idex_b_q;
            ALU_OR:    ex_result_s = idex_a_q | idex_b_q;
            ALU_XOR:   ex_result_s = idex_a_q ^ idex_b_q;
            ALU_NOR:   ex_result_s = ~(idex_a_q | idex_b_q);
            ALU_SLT:   ex_result_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(idex_a_q) < $signed(idex_b_q))};
            ALU_SLTU:  ex_result_s = {{(DATA_WIDTH-1){1'b0}}, (idex_a_q < idex_b_q)};
            ALU_SLL:   ex_result_s = idex_b_q << idex_shamt_q;
            ALU_SRL:   ex_result_s = idex_b_q >> idex_shamt_q;
            ALU_SRA:   ex_result_s = $signed(idex_b_q) >>> idex_shamt_q;
            ALU_PASSB: ex_result_s = idex_b_q;
            default:   ex_result_s = DATA_ZERO;
        endcase
        ex_ovf_s = idex_valid_q && idex_trap_q &&
                   (((idex_op_q == ALU_ADD) && (idex_a_q[MSB] == idex_b_q[MSB]) && (add_s[MSB] != idex_a_q[MSB])) ||
                    ((idex_op_q == ALU_SUB) && (idex_a_q[MSB] != idex_b_q[MSB]) && (sub_s[MSB] != idex_a_q[MSB])));
        ex_wr_s  = idex_valid_q && idex_wr_q && !ex_ovf_s;
    end

    // Next-state for PC and every pipeline register; a redirect overrides a fetch stall.
    always_comb begin
        ifid_instr_d = current_instruction;
        ifid_pc_d    = pc_q;
        if (redirect_s) begin
            pc_d = target_s;  ifid_valid_d = 1'b0;
        end else if (fetch_valid) begin
            pc_d = pc_q + PC_WIDTH'(32'd4);  ifid_valid_d = 1'b1;
        end else begin
            pc_d = pc_q;  ifid_valid_d = 1'b0;
        end
        idex_valid_d  = ifid_valid_q && dec_legal_s;
        idex_wr_d     = ifid_valid_q && dec_legal_s && dec_writes_s && (dest_s != REG_ZERO);
        idex_trap_d   = dec_trap_s;
        idex_op_d     = dec_op_s;
        idex_a_d      = fwd_a_s;
        idex_b_d      = op_b_s;
        idex_shamt_d  = shamt_s;
        idex_dest_d   = dest_s;
        exmem_valid_d = idex_valid_q && !ex_ovf_s;
        exmem_wr_d    = ex_wr_s;
        exmem_dest_d  = idex_dest_q;
        exmem_res_d   = ex_result_s;
        memwb_valid_d = exmem_valid_q;
        memwb_wr_d    = exmem_valid_q && exmem_wr_q;
        memwb_dest_d  = exmem_dest_q;
        memwb_res_d   = exmem_res_q;
        illegal_d     = ifid_valid_q && !dec_legal_s;
        overflow_d    = ex_ovf_s;
    end

    // Pipeline state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;  ifid_pc_q <= {PC_WIDTH{1'b0}};  ifid_valid_q <= 1'b0;  ifid_instr_q <= 32'd0;
            idex_valid_q <= 1'b0;  idex_wr_q <= 1'b0;  idex_trap_q <= 1'b0;  idex_op_q <= ALU_ADD;
            idex_a_q <= DATA_ZERO;  idex_b_q <= DATA_ZERO;  idex_shamt_q <= 5'd0;  idex_dest_q <= REG_ZERO;
            exmem_valid_q <= 1'b0;  exmem_wr_q <= 1'b0;  exmem_dest_q <= REG_ZERO;  exmem_res_q <= DATA_ZERO;
            memwb_valid_q <= 1'b0;  memwb_wr_q <= 1'b0;  memwb_dest_q <= REG_ZERO;  memwb_res_q <= DATA_ZERO;
            illegal_q <= 1'b0;  overflow_q <= 1'b0;
        end else begin
            pc_q <= pc_d;  ifid_pc_q <= ifid_pc_d;  ifid_valid_q <= ifid_valid_d;  ifid_instr_q <= ifid_instr_d;
            idex_valid_q <= idex_valid_d;  idex_wr_q <= idex_wr_d;  idex_trap_q <= idex_trap_d;  idex_op_q <= idex_op_d;
            idex_a_q <= idex_a_d;  idex_b_q <= idex_b_d;  idex_shamt_q <= idex_shamt_d;  idex_dest_q <= idex_dest_d;
            exmem_valid_q <= exmem_valid_d;  exmem_wr_q <= exmem_wr_d;  exmem_dest_q <= exmem_dest_d;  exmem_res_q <= exmem_res_d;
            memwb_valid_q <= memwb_valid_d;  memwb_wr_q <= memwb_wr_d;  memwb_dest_q <= memwb_dest_d;  memwb_res_q <= memwb_res_d;
            illegal_q <= illegal_d;  overflow_q <= overflow_d;
        end
    end

    assign PC                           = pc_q;
    assign register_file_read_address_1 = rs_addr_s;
    assign register_file_read_address_2 = rt_addr_s;
    assign register_file_write_address  = memwb_dest_q;
    assign register_file_write_value    = memwb_res_q;
    assign register_file_write_enable   = memwb_wr_q;
    assign illegal_instr                = illegal_q;
    assign overflow                     = overflow_q;

`ifdef PIPE_PERF_COUNTERS_EN
    logic [31:0] cycle_count_q, cycle_count_d, retire_count_q, retire_count_d, stall_count_q, stall_count_d;

    // Free-running counters; retirement counts every valid instruction leaving WB.
    always_comb begin
        cycle_count_d  = cycle_count_q + 32'd1;
        retire_count_d = retire_count_q + {31'd0, memwb_valid_q};
        stall_count_d  = stall_count_q + {31'd0, !fetch_valid};
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count_q <= 32'd0;  retire_count_q <= 32'd0;  stall_count_q <= 32'd0;
        end else begin
            cycle_count_q <= cycle_count_d;  retire_count_q <= retire_count_d;  stall_count_q <= stall_count_d;
        end
    end

    assign cycle_count       = cycle_count_q;
    assign retire_count      = retire_count_q;
    assign fetch_stall_count = stall_count_q;
`endif

endmodule
